// File: rtl/fp_div_pkg.sv
// fp_div_pkg: state encoding and constants shared by the FP divider arbiter.
// Optional watchdog is enabled by defining FP_DIV_TIMEOUT_EN.
package fp_div_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESPOND   = 3'd4
    } arbState_t;

    localparam logic [31:0] QNAN_32 = 32'h7FC00000;

endpackage

// File: rtl/fp_div_arbiter_rr_priority_pick.sv
// rr_priority_pick: combinational round-robin pick starting at rrPtr.
// Returns a one-hot winner and a flag saying any request was present.
module rr_priority_pick
    import fp_div_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rrPtr,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // Walk requesters from rrPtr upward with wrap; first live one wins.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rrPtr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin sharing of one FP divider among requesters.
// Define FP_DIV_TIMEOUT_EN to add the wait watchdog and the err output.
module fp_div_arbiter
    import fp_div_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] op_a,
    input  logic [NUM_REQ*WIDTH-1:0] op_b,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic [WIDTH-1:0]         result,
`ifdef FP_DIV_TIMEOUT_EN
    output logic                     err,
`endif
    output logic                     div_start,
    output logic [WIDTH-1:0]         div_a,
    output logic [WIDTH-1:0]         div_b,
    input  logic                     div_finish,
    input  logic [WIDTH-1:0]         div_result
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arbState_t          state;
    arbState_t          stateNext;
    logic [PTR_W-1:0]   rrPtr;
    logic [PTR_W-1:0]   ownerIdx;
    logic [PTR_W-1:0]   pickIdx;
    logic [NUM_REQ-1:0] pick;
    logic               pickValid;
    logic               grantNow;
    logic               finishNow;
    logic               timeoutHit;
    logic               forceNow;
    logic [WIDTH-1:0]   selA;
    logic [WIDTH-1:0]   selB;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) uPick (
        .req   (req),
        .rrPtr (rrPtr),
        .pick  (pick),
        .valid (pickValid)
    );

    // Operand mux and owner index for the one-hot winner.
    always_comb begin
        pickIdx = '0;
        selA    = '0;
        selB    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pickIdx = PTR_W'(i);
                selA    = op_a[i*WIDTH +: WIDTH];
                selB    = op_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign grantNow  = (state == IDLE) && pickValid && div_finish;
    assign finishNow = (state == WAIT_DONE) && div_finish;
    assign forceNow  = timeoutHit && !finishNow;

`ifdef FP_DIV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] waitCnt;
    logic             errFlag;
    logic             waiting;

    assign waiting    = (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign timeoutHit = waiting && (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err        = errFlag && (state == RESPOND);

    // Watchdog: counts cycles spent waiting, flags a forced response.
    always_ff @(posedge clock) begin
        if (reset) begin
            waitCnt <= '0;
            errFlag <= 1'b0;
        end else if (grantNow) begin
            waitCnt <= '0;
            errFlag <= 1'b0;
        end else if (waiting) begin
            waitCnt <= waitCnt + 1'b1;
            if (forceNow) begin
                errFlag <= 1'b1;
            end
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state plus the start and done strobes decoded from state.
    always_comb begin
        stateNext = state;
        div_start = 1'b0;
        done      = '0;
        unique case (state)
            IDLE: begin
                if (grantNow) begin
                    stateNext = LAUNCH;
                end
            end
            LAUNCH: begin
                div_start = 1'b1;
                stateNext = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (forceNow) begin
                    stateNext = RESPOND;
                end else if (!div_finish) begin
                    stateNext = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (finishNow || forceNow) begin
                    stateNext = RESPOND;
                end
            end
            RESPOND: begin
                done      = gnt;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Grant, operand latch, result capture and pointer advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            gnt      <= '0;
            result   <= '0;
            div_a    <= '0;
            div_b    <= '0;
            rrPtr    <= '0;
            ownerIdx <= '0;
        end else begin
            if (grantNow) begin
                gnt      <= pick;
                div_a    <= selA;
                div_b    <= selB;
                ownerIdx <= pickIdx;
            end
            if (finishNow) begin
                result <= div_result;
            end
`ifdef FP_DIV_TIMEOUT_EN
            else if (forceNow) begin
                result <= QNAN_32[WIDTH-1:0];
            end
`endif
            if (state == RESPOND) begin
                gnt <= '0;
                if (ownerIdx == PTR_W'(NUM_REQ - 1)) begin
                    rrPtr <= '0;
                end else begin
                    rrPtr <= ownerIdx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter: self-checking bench with a stand-in divider.
// Build with FP_DIV_TIMEOUT_EN defined to also exercise the watchdog.
module tb_fp_div_arbiter;

    localparam int N = 4;
    localparam int W = 32;
`ifdef FP_DIV_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] op_a = '0;
    logic [N*W-1:0] op_b = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [W-1:0]   result;
    logic           div_start;
    logic [W-1:0]   div_a;
    logic [W-1:0]   div_b;
    logic           div_finish;
    logic [W-1:0]   div_result;
`ifdef FP_DIV_TIMEOUT_EN
    logic           err;
`endif

    int checks = 0;
    int errors = 0;

    fp_div_arbiter #(
        .NUM_REQ        (N),
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .gnt        (gnt),
        .done       (done),
        .result     (result),
`ifdef FP_DIV_TIMEOUT_EN
        .err        (err),
`endif
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_finish (div_finish),
        .div_result (div_result)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Stand-in quotient; the 5.0/2.0 pair yields the true 2.5.
    function automatic logic [31:0] divModel(input logic [31:0] a,
                                             input logic [31:0] b);
        if (a == 32'h40A00000 && b == 32'h40000000) return 32'h40200000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0001;
    endfunction

    function automatic int rrWinner(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (((r >> j) & N'(1)) != '0) return j;
        end
        return -1;
    endfunction

    function automatic int oneHotIdx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (((v >> k) & N'(1)) != '0) return k;
        end
        return -1;
    endfunction

    // Divider stand-in: busy the cycle after start, idle after calc cycles.
    logic        finM = 1'b1;
    logic        holdBusy = 1'b0;
    logic        stuck = 1'b0;
    logic [31:0] mdA;
    logic [31:0] mdB;
    int          remain = 0;
    int          calcFixed = 0;

    assign div_finish = finM && !holdBusy;

    always @(posedge clock) begin
        if (reset) begin
            finM       <= 1'b1;
            remain     <= 0;
            div_result <= '0;
        end else if (div_start) begin
            finM   <= 1'b0;
            mdA    <= div_a;
            mdB    <= div_b;
            remain <= (calcFixed != 0) ? calcFixed : int'($urandom_range(6, 1));
        end else if (!finM && !stuck) begin
            if (remain <= 1) begin
                finM       <= 1'b1;
                div_result <= divModel(mdA, mdB);
            end else begin
                remain <= remain - 1;
            end
        end
    end

    // Reference model: expected owner, operands and result per transaction.
    int             mPtr = 0;
    int             mStarts = 0;
    logic [N-1:0]   mPrevReq = '0;
    logic [N-1:0]   mPrevGnt = '0;
    logic [N-1:0]   mOwner = '0;
    logic [N*W-1:0] mPrevOpA = '0;
    logic [N*W-1:0] mPrevOpB = '0;
    logic           mPrevFin = 1'b1;
    logic [31:0]    mA = '0;
    logic [31:0]    mB = '0;

    always @(negedge clock) begin
        int           w;
        logic [N-1:0] expG;
        if (reset) begin
            mPtr   = 0;
            mOwner = '0;
        end else begin
            if (mPrevGnt == '0 && gnt != '0) begin
                w    = rrWinner(mPrevReq, mPtr);
                expG = (w < 0) ? '0 : (N'(1) << w);
                check("grant_pick", gnt, expG);
                check("grant_ready", mPrevFin, 1'b1);
                if (w >= 0) begin
                    mA = mPrevOpA[w*W +: W];
                    mB = mPrevOpB[w*W +: W];
                    check("grant_div_a", div_a, mA);
                    check("grant_div_b", div_b, mB);
                    mOwner = expG;
                end
                mStarts = 0;
            end
            if (div_start) mStarts++;
            if (mOwner != '0) check("gnt_held", gnt, mOwner);
            if (done != '0) begin
                check("done_owner", done, mOwner);
                check("done_one_start", mStarts, 1);
`ifdef FP_DIV_TIMEOUT_EN
                check("done_err", err, stuck);
                check("done_result", result, stuck ? QNAN : divModel(mA, mB));
`else
                check("done_result", result, divModel(mA, mB));
`endif
                if (mOwner != '0) mPtr = (oneHotIdx(mOwner) + 1) % N;
                mOwner = '0;
            end
        end
        mPrevReq = req;
        mPrevGnt = gnt;
        mPrevOpA = op_a;
        mPrevOpB = op_b;
        mPrevFin = div_finish;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic setOp(input int i, input logic [31:0] a, input logic [31:0] b);
        op_a[i*W +: W] = a;
        op_b[i*W +: W] = b;
    endtask

    task automatic dropReq(input int i);
        if (i >= 0) req = req & ~(N'(1) << i);
    endtask

    task automatic waitDone(input string name, output int idx);
        idx = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (done != '0) begin
                idx = oneHotIdx(done);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s: no done within 200 cycles", name);
    endtask

    typedef struct {
        logic [N-1:0]      mask;
        logic [31:0]       a0;
        logic [31:0]       b0;
        int                calc;
        int                n;
        logic [3:0][1:0]   order;
        logic [31:0]       res0;
        bit                hasRes0;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int           got;
        int           bad;
        int           nDone;
        int           maxAge;
        int           age [N];
        bit           pend [N];
        logic [N-1:0] dn;

        vecs[0] = '{4'b0001, 32'h40A00000, 32'h40000000, 3, 1,
                    8'b00_00_00_00, 32'h40200000, 1'b1};
        vecs[1] = '{4'b1111, 32'h0, 32'h0, 2, 4,
                    8'b11_10_01_00, 32'h0, 1'b0};
        vecs[2] = '{4'b1010, 32'h0, 32'h0, 1, 2,
                    8'b00_00_11_01, 32'h0, 1'b0};
        vecs[3] = '{4'b0110, 32'h0, 32'h0, 5, 2,
                    8'b00_00_10_01, 32'h0, 1'b0};
        vecs[4] = '{4'b1100, 32'h0, 32'h0, 4, 2,
                    8'b00_00_11_10, 32'h0, 1'b0};

        // Reset values.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_start", div_start, 0);
        check("rst_result", result, 0);
        check("rst_div_a", div_a, 0);
        check("rst_div_b", div_b, 0);
        tick();

        // Table-driven arbitration order and single-request result.
        for (int v = 0; v < 5; v++) begin
            doReset();
            calcFixed = vecs[v].calc;
            for (int i = 0; i < N; i++) setOp(i, $urandom, $urandom);
            if (vecs[v].hasRes0) setOp(0, vecs[v].a0, vecs[v].b0);
            req = vecs[v].mask;
            for (int k = 0; k < vecs[v].n; k++) begin
                waitDone($sformatf("vec%0d_wait%0d", v, k), got);
                check($sformatf("vec%0d_order%0d", v, k), got, vecs[v].order[k]);
                if (k == 0 && vecs[v].hasRes0)
                    check("vec_result_2p5", result, vecs[v].res0);
                tick();
                dropReq(got);
            end
        end

        // Pointer wraps to 0 after serving requester 3.
        doReset();
        calcFixed = 2;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            waitDone("wrap_drain", got);
            tick();
            dropReq(got);
        end
        req = 4'b1001;
        waitDone("wrap_next", got);
        check("wrap_ptr_zero", got, 0);
        tick();
        dropReq(got);
        waitDone("wrap_last", got);
        check("wrap_then_3", got, 3);
        tick();
        dropReq(got);

        // Fairness: requester 0 re-requests at once, 2 goes first.
        doReset();
        req = 4'b0101;
        waitDone("fair_first", got);
        check("fair_first_0", got, 0);
        waitDone("fair_second", got);
        check("fair_then_2", got, 2);
        tick();
        dropReq(got);
        waitDone("fair_third", got);
        check("fair_back_0", got, 0);
        tick();
        dropReq(got);

        // Busy divider in IDLE blocks the grant.
        doReset();
        holdBusy = 1'b1;
        req = 4'b0001;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (gnt != '0 || div_start) bad++;
        end
        check("busy_no_grant", bad, 0);
        tick();
        holdBusy = 1'b0;
        waitDone("busy_release", got);
        check("busy_then_0", got, 0);
        tick();
        dropReq(got);

        // Reset while waiting for the quotient.
        doReset();
        calcFixed = 20;
        req = 4'b0100;
        bad = 1;
        for (int c = 0; c < 50 && bad != 0; c++) begin
            @(negedge clock);
            if (gnt != '0 && !div_finish) bad = 0;
        end
        check("mid_reached_wait", bad, 0);
        repeat (3) @(negedge clock);
        tick();
        reset = 1'b1;
        req = 4'b1001;
        calcFixed = 2;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_start", div_start, 0);
        waitDone("mid_fresh", got);
        check("mid_fresh_0", got, 0);
        tick();
        dropReq(got);
        waitDone("mid_fresh2", got);
        check("mid_fresh_3", got, 3);
        tick();
        dropReq(got);

`ifdef FP_DIV_TIMEOUT_EN
        // Divider never finishes: watchdog answers with qNaN and err.
        doReset();
        stuck = 1'b1;
        req = 4'b0001;
        bad = 1;
        for (int c = 0; c < 20 && bad != 0; c++) begin
            @(negedge clock);
            if (div_start) bad = 0;
        end
        check("to_started", bad, 0);
        got = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (done != '0) break;
            got++;
        end
        check("to_wait_cycles", got, TO);
        check("to_done", done, 4'b0001);
        check("to_err", err, 1'b1);
        check("to_qnan", result, QNAN);
        tick();
        dropReq(0);
        stuck = 1'b0;
`endif

        // Randomized traffic against the reference model.
        doReset();
        calcFixed = 0;
        nDone = 0;
        maxAge = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            age[i]  = 0;
        end
        for (int c = 0; c < 2300; c++) begin
            @(negedge clock);
            dn = done;
            tick();
            for (int i = 0; i < N; i++) begin
                if (pend[i] && ((dn >> i) & N'(1)) != '0) begin
                    pend[i] = 1'b0;
                    dropReq(i);
                    nDone++;
                end else if (!pend[i] && c < 2000 && $urandom_range(3, 0) == 0) begin
                    setOp(i, $urandom, $urandom);
                    req = req | (N'(1) << i);
                    pend[i] = 1'b1;
                    age[i] = 0;
                end else if (pend[i] && ((gnt >> i) & N'(1)) != '0
                             && $urandom_range(7, 0) == 0) begin
                    setOp(i, $urandom, $urandom);
                    if ($urandom_range(1, 0) == 0) dropReq(i);
                end
                if (pend[i]) begin
                    age[i]++;
                    if (age[i] > maxAge) maxAge = age[i];
                end
            end
        end
        bad = 0;
        for (int i = 0; i < N; i++) if (pend[i]) bad++;
        check("rand_drained", bad, 0);
        check("rand_progress", nDone > 100, 1'b1);
        check("rand_no_starve", maxAge < 150, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
